// File: rtl/lsu_pkg.sv
// Load/store opcode encoding shared by the execute and memory stages.
package lsu_pkg;

    typedef enum logic [2:0] {
        LsuLb, LsuLh, LsuLw, LsuLbu, LsuLhu, LsuSb, LsuSh, LsuSw
    } lsuop_t;

endpackage

// File: rtl/mem_stage_pkg.sv
// Memory-stage types: EX/MEM payload, writeback and forwarding bundles, FSM states.
package mem_stage_pkg;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] opr_res;
        logic [31:0] opr_b;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
        lsuop_t      lsuop;
    } ex_stage_out_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] opr_res;
        logic [31:0] ld_data;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rf_en;
        logic [1:0]  wb_sel;
    } mem_stage_out_t;

    typedef struct packed {
        logic        rf_en;
        logic [4:0]  rd;
        logic [31:0] opr_res;
    } ex_stage_in_frm_mem_t;

    typedef enum logic [1:0] {StIdle, StReq, StRsp} mem_state_t;

    function automatic logic is_load(lsuop_t op);
        return op inside {LsuLb, LsuLh, LsuLw, LsuLbu, LsuLhu};
    endfunction

    function automatic logic is_store(lsuop_t op);
        return op inside {LsuSb, LsuSh, LsuSw};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store byte enables and data replication, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  lsuop_t      lsuop_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        // Shifts in a 4-bit context drop enables past the addressed word.
        case (lsuop_i)
            LsuSb: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LsuSh: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        ld_data_o = shifted;
        case (lsuop_i)
            LsuLb:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LsuLbu:  ld_data_o = {24'b0, shifted[7:0]};
            LsuLh:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LsuLhu:  ld_data_o = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-bus FSM and stall generation.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage
    import lsu_pkg::*;
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  ex_stage_out_t           mem_stage_in,
    input  logic                    ex_flush,
    output logic                    mem_busy,
    output logic                    dbus_req_valid,
    input  logic                    dbus_req_ready,
    output logic [31:0]             dbus_addr,
    output logic                    dbus_we,
    output logic [3:0]              dbus_be,
    output logic [DATA_WIDTH-1:0]   dbus_wdata,
    input  logic                    dbus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   dbus_rdata,
    output mem_stage_out_t          mem_stage_out,
    output ex_stage_in_frm_mem_t    mem_fwd
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                    misalign_exc
`endif
);

    mem_state_t    state_q, state_d;
    ex_stage_out_t ent_q, ent_d;
    logic          vld_q, vld_d;
    logic          trap_q, trap_d;
    logic          in_misalign, start, ent_ld, ent_st, done_st, done_ld;
    logic [31:0]   ld_data;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        in_misalign = 1'b0;
        case (mem_stage_in.lsuop)
            LsuLh, LsuLhu, LsuSh: in_misalign = mem_stage_in.opr_res[0];
            LsuLw, LsuSw:         in_misalign = |mem_stage_in.opr_res[1:0];
            default: ;
        endcase
    end
    assign misalign_exc = trap_q;
`else
    assign in_misalign = 1'b0;
`endif

    assign start   = !ex_flush && mem_stage_in.dm_en && !in_misalign;
    assign ent_ld  = is_load(ent_q.lsuop);
    assign ent_st  = is_store(ent_q.lsuop);
    assign done_st = (state_q == StReq) && ent_st && dbus_req_ready;
    assign done_ld = (state_q == StRsp) && dbus_rsp_valid;

    assign mem_busy = ((state_q == StReq) && !(dbus_req_ready && ent_st))
                    || ((state_q == StRsp) && !dbus_rsp_valid)
                    || ((state_q == StReq) && ent_ld);

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        vld_d   = vld_q;
        trap_d  = trap_q;
        if (!mem_busy) begin
            // Every non-stalled edge retires the current entry and takes the next one.
            ent_d   = mem_stage_in;
            vld_d   = !ex_flush;
            trap_d  = !ex_flush && mem_stage_in.dm_en && in_misalign;
            state_d = start ? StReq : StIdle;
            if (ex_flush) begin
                ent_d.rf_en = 1'b0;
            end
        end else if ((state_q == StReq) && dbus_req_ready && ent_ld) begin
            state_d = StRsp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ent_q   <= '0;
            vld_q   <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            trap_q  <= trap_d;
        end
    end

    lsu_align u_lsu_align (
        .addr_lo_i (ent_q.opr_res[1:0]),
        .lsuop_i   (ent_q.lsuop),
        .st_data_i (ent_q.opr_b),
        .rdata_i   (dbus_rdata),
        .be_o      (dbus_be),
        .wdata_o   (dbus_wdata),
        .ld_data_o (ld_data)
    );

    assign dbus_req_valid = (state_q == StReq);
    assign dbus_addr      = {ent_q.opr_res[31:2], 2'b00};
    assign dbus_we        = ent_st;

    always_comb begin
        mem_stage_out         = '0;
        mem_stage_out.valid   = vld_q && (!ent_q.dm_en || trap_q || done_st || done_ld);
        mem_stage_out.opr_res = ent_q.opr_res;
        mem_stage_out.ld_data = ld_data;
        mem_stage_out.pc4     = ent_q.pc4;
        mem_stage_out.rd      = ent_q.rd;
        mem_stage_out.rf_en   = ent_q.rf_en && !trap_q;
        mem_stage_out.wb_sel  = ent_q.wb_sel;
    end

    always_comb begin
        mem_fwd         = '0;
        mem_fwd.rf_en   = vld_q && ent_q.rf_en && !trap_q;
        mem_fwd.rd      = ent_q.rd;
        mem_fwd.opr_res = ent_q.opr_res;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage; randomized ops checked against a lane-arithmetic model.
module tb_mem_stage;
    import lsu_pkg::*;
    import mem_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    ex_stage_out_t        mem_stage_in;
    logic                 ex_flush;
    logic                 mem_busy;
    logic                 dbus_req_valid;
    logic                 dbus_req_ready;
    logic [31:0]          dbus_addr;
    logic                 dbus_we;
    logic [3:0]           dbus_be;
    logic [31:0]          dbus_wdata;
    logic                 dbus_rsp_valid;
    logic [31:0]          dbus_rdata;
    mem_stage_out_t       mem_stage_out;
    ex_stage_in_frm_mem_t mem_fwd;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 misalign_exc;
`endif

    int vecs = 0;
    int errs = 0;

    mem_stage #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_stage_in   (mem_stage_in),
        .ex_flush       (ex_flush),
        .mem_busy       (mem_busy),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_addr      (dbus_addr),
        .dbus_we        (dbus_we),
        .dbus_be        (dbus_be),
        .dbus_wdata     (dbus_wdata),
        .dbus_rsp_valid (dbus_rsp_valid),
        .dbus_rdata     (dbus_rdata),
        .mem_stage_out  (mem_stage_out),
        .mem_fwd        (mem_fwd)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc   (misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-lane arithmetic on integers.
    function automatic logic [3:0] ref_be(lsuop_t op, logic [1:0] a);
        int unsigned m;
        m = 15;
        if (op == LsuSb) m = (1 << int'(a)) % 16;
        if (op == LsuSh) m = (3 << int'(a)) % 16;
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(lsuop_t op, logic [31:0] d);
        if (op == LsuSb) return (d % 256) * 32'h0101_0101;
        if (op == LsuSh) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_ld(lsuop_t op, logic [1:0] a, logic [31:0] r);
        int unsigned w, b, h;
        w = r / (1 << (8 * int'(a)));
        b = w % 256;
        h = w % 65536;
        case (op)
            LsuLb:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LsuLbu:  return b;
            LsuLh:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LsuLhu:  return h;
            default: return w;
        endcase
    endfunction

    function automatic ex_stage_out_t mk_op(logic [31:0] res, logic [31:0] b, logic dm,
                                            lsuop_t op);
        ex_stage_out_t o;
        o.opr_res = res;
        o.opr_b   = b;
        o.rd      = 5'($urandom);
        o.pc4     = $urandom;
        o.rf_en   = !(dm && is_store(op));
        o.dm_en   = dm;
        o.wb_sel  = 2'($urandom);
        o.lsuop   = op;
        return o;
    endfunction

    // Presents one op, holds it until captured, then walks the bus protocol with the given
    // ready and response delays, checking every cycle until the op retires.
    task automatic run_op(input string name, input ex_stage_out_t op, input int rdly,
                          input int sdly, input logic [31:0] rdat);
        logic ld, st, exp_busy, exp_vld;
        int stalls, pulses, exp_stalls;
        mem_stage_out_t eo;
        ex_stage_in_frm_mem_t ef;
        ld = op.dm_en && is_load(op.lsuop);
        st = op.dm_en && is_store(op.lsuop);
        ef.rf_en = op.rf_en;
        ef.rd = op.rd;
        ef.opr_res = op.opr_res;
        eo.valid = 1'b1;
        eo.opr_res = op.opr_res;
        eo.pc4 = op.pc4;
        eo.rd = op.rd;
        eo.rf_en = op.rf_en;
        eo.wb_sel = op.wb_sel;
        stalls = 0;
        pulses = 0;
        mem_stage_in = op;
        ex_flush = 1'b0;
        dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if (mem_busy !== 1'b0) begin
            errs++;
            $display("FAIL %s pre_capture_busy got=%0b want=0", name, mem_busy);
        end
        step();
        ex_flush = 1'b1;
        if (!ld && !st) begin
            dbus_rdata = $urandom;
            @(negedge clk);
            eo.ld_data = ref_ld(op.lsuop, op.opr_res[1:0], dbus_rdata);
            vecs++;
            if (mem_stage_out !== eo || mem_busy !== 1'b0 || dbus_req_valid !== 1'b0) begin
                errs++;
                $display("FAIL %s alu_out got=%h busy=%0b req=%0b want=%h busy=0 req=0",
                         name, mem_stage_out, mem_busy, dbus_req_valid, eo);
            end
            vecs++;
            if (mem_fwd !== ef) begin
                errs++;
                $display("FAIL %s alu_fwd got=%h want=%h", name, mem_fwd, ef);
            end
            pulses += int'(mem_stage_out.valid);
            stalls += int'(mem_busy);
            step();
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                dbus_req_ready = (k == rdly);
                dbus_rdata = $urandom;
                dbus_rsp_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                exp_busy = ld || (k != rdly);
                exp_vld = st && (k == rdly);
                vecs++;
                if (dbus_req_valid !== 1'b1 || dbus_addr !== {op.opr_res[31:2], 2'b00}
                    || dbus_we !== st) begin
                    errs++;
                    $display("FAIL %s req got v=%0b a=%h we=%0b want v=1 a=%h we=%0b", name,
                             dbus_req_valid, dbus_addr, dbus_we, {op.opr_res[31:2], 2'b00}, st);
                end
                if (st) begin
                    vecs++;
                    if (dbus_be !== ref_be(op.lsuop, op.opr_res[1:0])
                        || dbus_wdata !== ref_wdata(op.lsuop, op.opr_b)) begin
                        errs++;
                        $display("FAIL %s store_lanes got be=%b wd=%h want be=%b wd=%h", name,
                                 dbus_be, dbus_wdata, ref_be(op.lsuop, op.opr_res[1:0]),
                                 ref_wdata(op.lsuop, op.opr_b));
                    end
                end
                vecs++;
                if (mem_busy !== exp_busy || mem_stage_out.valid !== exp_vld) begin
                    errs++;
                    $display("FAIL %s req_cycle%0d got busy=%0b vld=%0b want busy=%0b vld=%0b",
                             name, k, mem_busy, mem_stage_out.valid, exp_busy, exp_vld);
                end
                vecs++;
                if (mem_fwd !== ef) begin
                    errs++;
                    $display("FAIL %s fwd got=%h want=%h", name, mem_fwd, ef);
                end
                pulses += int'(mem_stage_out.valid);
                stalls += int'(mem_busy);
                step();
            end
            dbus_req_ready = 1'b0;
            if (ld) begin
                for (int j = 0; j <= sdly; j++) begin
                    dbus_rsp_valid = (j == sdly);
                    dbus_rdata = (j == sdly) ? rdat : $urandom;
                    @(negedge clk);
                    vecs++;
                    if (dbus_req_valid !== 1'b0 || mem_busy !== (j != sdly)
                        || mem_stage_out.valid !== (j == sdly)) begin
                        errs++;
                        $display("FAIL %s rsp_cycle%0d got req=%0b busy=%0b vld=%0b", name,
                                 j, dbus_req_valid, mem_busy, mem_stage_out.valid);
                    end
                    if (j == sdly) begin
                        eo.ld_data = ref_ld(op.lsuop, op.opr_res[1:0], rdat);
                        vecs++;
                        if (mem_stage_out !== eo) begin
                            errs++;
                            $display("FAIL %s load_out got=%h want=%h", name, mem_stage_out,
                                     eo);
                        end
                    end
                    pulses += int'(mem_stage_out.valid);
                    stalls += int'(mem_busy);
                    step();
                end
                dbus_rsp_valid = 1'b0;
            end
        end
        exp_stalls = st ? rdly : (ld ? rdly + 1 + sdly : 0);
        vecs++;
        if (stalls !== exp_stalls || pulses !== 1) begin
            errs++;
            $display("FAIL %s stall_count got stalls=%0d pulses=%0d want stalls=%0d pulses=1",
                     name, stalls, pulses, exp_stalls);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_flush = 1'b1;
        mem_stage_in = '0;
        dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b0;
        dbus_rdata = '0;
        repeat (2) step();
        vecs++;
        if (dbus_req_valid !== 1'b0 || mem_busy !== 1'b0 || mem_stage_out.valid !== 1'b0
            || mem_fwd.rf_en !== 1'b0) begin
            errs++;
            $display("FAIL reset_outputs got req=%0b busy=%0b vld=%0b fwd_en=%0b want 0000",
                     dbus_req_valid, mem_busy, mem_stage_out.valid, mem_fwd.rf_en);
        end
        vecs++;
        if (mem_stage_out.opr_res !== 32'h0 || mem_stage_out.pc4 !== 32'h0
            || dbus_addr !== 32'h0) begin
            errs++;
            $display("FAIL reset_contents got res=%h pc4=%h addr=%h want 0", 
                     mem_stage_out.opr_res, mem_stage_out.pc4, dbus_addr);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        vecs++;
        if (misalign_exc !== 1'b0) begin
            errs++;
            $display("FAIL reset_misalign got=%0b want=0", misalign_exc);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        ex_stage_out_t op;
        op = mk_op(32'h1234, $urandom, 1'b0, LsuLb);
        op.rf_en = 1'b1;
        run_op("alu", op, 0, 0, 0);
        op = mk_op(32'h9990, $urandom, 1'b1, LsuSw);
        mem_stage_in = op;
        ex_flush = 1'b1;
        step();
        @(negedge clk);
        vecs++;
        if (dbus_req_valid !== 1'b0 || mem_stage_out.valid !== 1'b0 || mem_fwd.rf_en !== 1'b0
            || mem_stage_out.rf_en !== 1'b0) begin
            errs++;
            $display("FAIL flush got req=%0b vld=%0b fwd_en=%0b rf_en=%0b want 0000",
                     dbus_req_valid, mem_stage_out.valid, mem_fwd.rf_en, mem_stage_out.rf_en);
        end
        step();
    endtask

    task automatic test_store();
        run_op("sb_1003", mk_op(32'h1003, 32'h0000_00AB, 1'b1, LsuSb), 0, 0, 0);
        run_op("sh_1002", mk_op(32'h1002, 32'h1234_BEEF, 1'b1, LsuSh), 2, 0, 0);
        run_op("sw_1000", mk_op(32'h1000, 32'hCAFE_F00D, 1'b1, LsuSw), 1, 0, 0);
    endtask

    task automatic test_load();
        run_op("lb_2001", mk_op(32'h2001, 0, 1'b1, LsuLb), 0, 0, 32'h0000_8000);
        run_op("lbu_2001", mk_op(32'h2001, 0, 1'b1, LsuLbu), 0, 0, 32'h0000_8000);
        run_op("lh_2002", mk_op(32'h2002, 0, 1'b1, LsuLh), 0, 1, 32'h9876_0000);
        run_op("lhu_2002", mk_op(32'h2002, 0, 1'b1, LsuLhu), 1, 0, 32'h9876_0000);
    endtask

    task automatic test_lw_wait();
        run_op("lw_wait", mk_op(32'h2000, 0, 1'b1, LsuLw), 3, 2, 32'hDEAD_BEEF);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        ex_stage_out_t op;
        op = mk_op(32'h3002, 0, 1'b1, LsuLw);
        mem_stage_in = op;
        ex_flush = 1'b0;
        step();
        ex_flush = 1'b1;
        @(negedge clk);
        vecs++;
        if (dbus_req_valid !== 1'b0 || misalign_exc !== 1'b1 || mem_stage_out.valid !== 1'b1
            || mem_stage_out.rf_en !== 1'b0 || mem_busy !== 1'b0) begin
            errs++;
            $display("FAIL trap got req=%0b exc=%0b vld=%0b rf_en=%0b busy=%0b want 0 1 1 0 0",
                     dbus_req_valid, misalign_exc, mem_stage_out.valid, mem_stage_out.rf_en,
                     mem_busy);
        end
        step();
        @(negedge clk);
        vecs++;
        if (misalign_exc !== 1'b0 || dbus_req_valid !== 1'b0) begin
            errs++;
            $display("FAIL trap_pulse got exc=%0b req=%0b want 0 0", misalign_exc,
                     dbus_req_valid);
        end
        step();
`else
        run_op("sh_mis_1003", mk_op(32'h1003, 32'h0000_BEEF, 1'b1, LsuSh), 0, 0, 0);
        run_op("lw_mis_3002", mk_op(32'h3002, 0, 1'b1, LsuLw), 0, 0, 32'hA1B2_C3D4);
`endif
    endtask

    task automatic test_back_to_back();
        ex_stage_out_t l, s;
        logic [31:0] r;
        l = mk_op(32'h2002, 0, 1'b1, LsuLh);
        s = mk_op(32'h4000, 32'h5566_7788, 1'b1, LsuSw);
        r = 32'hF00F_1234;
        mem_stage_in = l;
        ex_flush = 1'b0;
        step();
        mem_stage_in = s;
        dbus_req_ready = 1'b1;
        step();
        dbus_req_ready = 1'b0;
        dbus_rsp_valid = 1'b1;
        dbus_rdata = r;
        @(negedge clk);
        vecs++;
        if (mem_stage_out.valid !== 1'b1 || mem_busy !== 1'b0
            || mem_stage_out.ld_data !== ref_ld(LsuLh, 2'd2, r)) begin
            errs++;
            $display("FAIL b2b_load got vld=%0b busy=%0b ld=%h want 1 0 %h",
                     mem_stage_out.valid, mem_busy, mem_stage_out.ld_data,
                     ref_ld(LsuLh, 2'd2, r));
        end
        step();
        ex_flush = 1'b1;
        dbus_rsp_valid = 1'b0;
        dbus_req_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (dbus_req_valid !== 1'b1 || dbus_addr !== 32'h4000 || dbus_we !== 1'b1
            || dbus_wdata !== 32'h5566_7788 || mem_stage_out.valid !== 1'b1) begin
            errs++;
            $display("FAIL b2b_store got req=%0b a=%h we=%0b wd=%h vld=%0b", dbus_req_valid,
                     dbus_addr, dbus_we, dbus_wdata, mem_stage_out.valid);
        end
        step();
        dbus_req_ready = 1'b0;
        @(negedge clk);
        vecs++;
        if (dbus_req_valid !== 1'b0 || mem_busy !== 1'b0) begin
            errs++;
            $display("FAIL b2b_idle got req=%0b busy=%0b want 0 0", dbus_req_valid, mem_busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem_stage_in = mk_op(32'h5000, 0, 1'b1, LsuLw);
        ex_flush = 1'b0;
        dbus_req_ready = 1'b1;
        dbus_rsp_valid = 1'b0;
        step();
        ex_flush = 1'b1;
        step();
        dbus_req_ready = 1'b0;
        @(negedge clk);
        vecs++;
        if (mem_busy !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_in_rsp busy got=%0b want=1", mem_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (mem_busy !== 1'b0 || dbus_req_valid !== 1'b0 || mem_stage_out.valid !== 1'b0
            || mem_fwd.rf_en !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_async got busy=%0b req=%0b vld=%0b fwd_en=%0b want 0000",
                     mem_busy, dbus_req_valid, mem_stage_out.valid, mem_fwd.rf_en);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        dbus_rsp_valid = 1'b1;
        dbus_rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (mem_stage_out.valid !== 1'b0 || mem_busy !== 1'b0 || dbus_req_valid !== 1'b0)
            begin
                errs++;
                $display("FAIL rstmid_stray%0d got vld=%0b busy=%0b req=%0b want 000", i,
                         mem_stage_out.valid, mem_busy, dbus_req_valid);
            end
            step();
        end
        dbus_rsp_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        ex_stage_out_t op;
        logic [31:0] a;
        logic [2:0] r;
        int kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            r = (kind == 1) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
            if (lsuop_t'(r) inside {LsuLh, LsuLhu, LsuSh}) a[0] = 1'b0;
            if (lsuop_t'(r) inside {LsuLw, LsuSw}) a[1:0] = 2'b00;
`endif
            op = mk_op(a, $urandom, kind != 0, lsuop_t'(r));
            run_op($sformatf("rand%0d", n), op, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_lw_wait();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
